fir_decim_fifo: RTL and testbench

Downstream stage of the FIR filter. It takes the filter's full-rate output samples and decimates them by DECIM. Each kept sample is rounded, right-shifted and saturated to OUT_WIDTH, then buffered in a small FIFO. The FIFO drains through a valid/ready interface to the next consumer and reports overflow and saturation status.

---
 rtl/fir_decim_fifo.sv | 114 +++++++++++
 tb/tb_fir_decim_fifo.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_decim_fifo.sv
// Decimator and output buffer behind the FIR: keeps every DECIM-th valid sample,
// rounds/shifts/saturates it to OUT_WIDTH and queues it in a small valid/ready FIFO.
module fir_decim_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 12,
  parameter int SHIFT      = 4,
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  input  logic signed [DATA_WIDTH-1:0]  y_in,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic signed [OUT_WIDTH-1:0]   m_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          sat,
  output logic [7:0]                    drop_count
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int PW  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int TW  = DATA_WIDTH + 1;
  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic [CW-1:0]        DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0]        PH_LAST = PW'(DECIM - 1);
  localparam logic signed [TW-1:0] RND     = (SHIFT > 0) ? (TW'(1) <<< RSH) : '0;
  localparam logic signed [TW-1:0] OMAX    = TW'((2 ** (OUT_WIDTH - 1)) - 1);
  localparam logic signed [TW-1:0] OMIN    = TW'(-(2 ** (OUT_WIDTH - 1)));

  // One guard bit keeps the rounding add from wrapping at full-scale positive input.
  function automatic logic signed [TW-1:0] round_shift(input logic signed [DATA_WIDTH-1:0] x);
    logic signed [TW-1:0] t;
    t = {x[DATA_WIDTH-1], x} + RND;
    return t >>> SHIFT;
  endfunction

  // Returns {saturated flag, clamped value}.
  function automatic logic [OUT_WIDTH:0] saturate(input logic signed [TW-1:0] r);
    if (r > OMAX)      return {1'b1, OMAX[OUT_WIDTH-1:0]};
    else if (r < OMIN) return {1'b1, OMIN[OUT_WIDTH-1:0]};
    else               return {1'b0, r[OUT_WIDTH-1:0]};
  endfunction

  logic [PW-1:0]                phase;
  logic                         keep_p0;
  logic [OUT_WIDTH:0]           res_p0;
  logic                         vld_p1;
  logic signed [OUT_WIDTH-1:0]  data_p1;
  logic signed [OUT_WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]                wr_ptr, rd_ptr;
  logic [CW-1:0]                count;
  logic                         pop, push, drop;

  // ---- p0: phase select and arithmetic on the incoming sample
  assign keep_p0 = in_valid && (phase == '0);
  assign res_p0  = saturate(round_shift(y_in));

  // ---- p1 -> FIFO: push arbitration against a same-cycle pop
  assign m_valid    = (count != '0);
  assign pop        = m_valid && m_ready;
  assign push       = vld_p1 && ((count < DEPTH_C) || pop);
  assign drop       = vld_p1 && !push;
  assign m_data     = m_valid ? mem[rd_ptr] : '0;
  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (keep_p0) data_p1 <= res_p0[OUT_WIDTH-1:0];
    if (push)    mem[wr_ptr] <= data_p1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase      <= '0;
      vld_p1     <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      sat        <= 1'b0;
      drop_count <= '0;
    end else if (flush) begin
      phase      <= '0;
      vld_p1     <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      sat        <= 1'b0;
      drop_count <= '0;
    end else begin
      if (in_valid) phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
      vld_p1 <= keep_p0;
      if (keep_p0 && res_p0[OUT_WIDTH]) sat <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_decim_fifo.sv
// Bench for fir_decim_fifo: DUT a runs DECIM=1, DUT b runs the default DECIM=4.
// Directed tables and sequences, then randomized traffic against a queue model.
module tb_fir_decim_fifo;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic               a_flush, a_in_valid, a_m_ready, a_m_valid, a_ovf, a_sat;
  logic signed [15:0] a_y;
  logic signed [11:0] a_m_data;
  logic [3:0]         a_count;
  logic [7:0]         a_drop;

  logic               b_flush, b_in_valid, b_m_ready, b_m_valid, b_ovf, b_sat;
  logic signed [15:0] b_y;
  logic signed [11:0] b_m_data;
  logic [3:0]         b_count;
  logic [7:0]         b_drop;

  fir_decim_fifo #(.DATA_WIDTH(16), .OUT_WIDTH(12), .SHIFT(4), .DECIM(1), .FIFO_DEPTH(8)) dut_a (
    .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_in_valid), .y_in(a_y),
    .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data), .fifo_count(a_count),
    .overflow(a_ovf), .sat(a_sat), .drop_count(a_drop));

  fir_decim_fifo #(.DATA_WIDTH(16), .OUT_WIDTH(12), .SHIFT(4), .DECIM(4), .FIFO_DEPTH(8)) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_in_valid), .y_in(b_y),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data), .fifo_count(b_count),
    .overflow(b_ovf), .sat(b_sat), .drop_count(b_drop));

  int tests = 0;
  int fails = 0;

  typedef struct {
    int y;
    int exp_data;
    int exp_sat;
  } vec_t;

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // floor((y + 8) / 16) clamped to the signed 12-bit range
  task automatic ref_val(input int y, output int v, output bit s);
    int num, q;
    num = y + 8;
    q = num / 16;
    if (num < 0 && q * 16 != num) q = q - 1;
    s = 1'b0;
    if (q > 2047)       begin q = 2047;  s = 1'b1; end
    else if (q < -2048) begin q = -2048; s = 1'b1; end
    v = q;
  endtask

  task automatic flush_a();
    a_flush = 1'b1; a_in_valid = 1'b0; cyc(); a_flush = 1'b0;
  endtask

  task automatic flush_b();
    b_flush = 1'b1; b_in_valid = 1'b0; cyc(); b_flush = 1'b0;
  endtask

  task automatic run_decim(input bit gaps, input string tag);
    int outq[$];
    int ncyc, first;
    flush_b();
    b_m_ready = 1'b1;
    ncyc = 0; first = -1;
    for (int i = 1; i <= 10; i++) begin
      if (gaps) begin
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
          b_in_valid = 1'b0; cyc();
          if (ncyc > 0) ncyc++;
          if (b_m_valid) begin outq.push_back(int'(b_m_data)); if (first < 0) first = ncyc; end
        end
      end
      b_in_valid = 1'b1; b_y = 16'(16 * i); cyc();
      ncyc++;
      if (b_m_valid) begin outq.push_back(int'(b_m_data)); if (first < 0) first = ncyc; end
    end
    b_in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc(); ncyc++;
      if (b_m_valid) outq.push_back(int'(b_m_data));
    end
    chk({tag, "_first_valid_cycle"}, first, 2);
    chk({tag, "_num_out"}, outq.size(), 3);
    if (outq.size() == 3) begin
      chk({tag, "_out0"}, outq[0], 1);
      chk({tag, "_out1"}, outq[1], 5);
      chk({tag, "_out2"}, outq[2], 9);
    end
  endtask

  task automatic fill_b_for_flush();
    flush_b();
    b_m_ready = 1'b0;
    for (int i = 0; i <= 20; i++) begin
      b_in_valid = 1'b1;
      b_y = (i == 0) ? 16'sd32767 : 16'(16 * i);
      cyc();
    end
    b_in_valid = 1'b0;
    chk("prefl_count", b_count, 5);
    chk("prefl_sat", b_sat, 1);
  endtask

  task automatic post_clear_b(input string tag);
    chk({tag, "_count"}, b_count, 0);
    chk({tag, "_mvalid"}, b_m_valid, 0);
    chk({tag, "_mdata"}, b_m_data, 0);
    chk({tag, "_sat"}, b_sat, 0);
    chk({tag, "_ovf"}, b_ovf, 0);
    chk({tag, "_drop"}, b_drop, 0);
  endtask

  task automatic phase_after_clear_b(input string tag);
    b_in_valid = 1'b1; b_y = 16'sd112; cyc();
    b_in_valid = 1'b0; cyc();
    chk({tag, "_new_count"}, b_count, 1);
    chk({tag, "_new_data"}, b_m_data, 7);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   q[$];
    bit   pv, psat, movf, msat, pop, iv, mr;
    int   pval, mdrop, nin, y;

    vecs[0] = '{100, 6, 0};
    vecs[1] = '{-100, -6, 0};
    vecs[2] = '{8, 1, 0};
    vecs[3] = '{7, 0, 0};
    vecs[4] = '{32767, 2047, 1};
    vecs[5] = '{-32768, -2048, 1};

    rst = 1'b1;
    a_flush = 0; a_in_valid = 0; a_y = 0; a_m_ready = 0;
    b_flush = 0; b_in_valid = 0; b_y = 0; b_m_ready = 0;
    cyc(); cyc();
    chk("rst_a_mvalid", a_m_valid, 0);
    chk("rst_a_mdata", a_m_data, 0);
    chk("rst_a_count", a_count, 0);
    chk("rst_a_ovf", a_ovf, 0);
    chk("rst_a_sat", a_sat, 0);
    chk("rst_a_drop", a_drop, 0);
    chk("rst_b_count", b_count, 0);
    rst = 1'b0;
    cyc();

    // rounding and saturation table, DECIM=1, m_ready=1
    a_m_ready = 1'b1;
    foreach (vecs[i]) begin
      a_in_valid = 1'b1; a_y = 16'(vecs[i].y); cyc();
      a_in_valid = 1'b0; cyc();
      chk($sformatf("tbl%0d_mvalid", i), a_m_valid, 1);
      chk($sformatf("tbl%0d_mdata", i), a_m_data, vecs[i].exp_data);
      chk($sformatf("tbl%0d_sat", i), a_sat, vecs[i].exp_sat);
      cyc();
      chk($sformatf("tbl%0d_popped", i), a_m_valid, 0);
    end

    run_decim(1'b0, "decim");
    run_decim(1'b1, "decim_gaps");

    // overflow: ten kept samples into an 8-deep FIFO with no consumer
    flush_a();
    a_m_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      a_in_valid = 1'b1; a_y = 16'(16 * i); cyc();
    end
    a_in_valid = 1'b0; cyc();
    chk("ovf_count", a_count, 8);
    chk("ovf_flag", a_ovf, 1);
    chk("ovf_drop", a_drop, 2);
    chk("ovf_hold_data", a_m_data, 1);
    a_m_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("drain%0d_data", k), a_m_data, k);
      cyc();
    end
    chk("drain_mvalid", a_m_valid, 0);
    chk("drain_count", a_count, 0);

    // full FIFO with simultaneous push and pop
    flush_a();
    a_m_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      a_in_valid = 1'b1; a_y = 16'(16 * i); cyc();
    end
    a_in_valid = 1'b0;
    chk("full_count", a_count, 8);
    a_m_ready = 1'b1; cyc();
    chk("pp_count", a_count, 8);
    chk("pp_ovf", a_ovf, 0);
    chk("pp_drop", a_drop, 0);
    for (int k = 2; k <= 9; k++) begin
      chk($sformatf("pp_drain%0d", k), a_m_data, k);
      cyc();
    end
    chk("pp_empty", a_m_valid, 0);

    // flush mid-stream with an in-flight sample
    fill_b_for_flush();
    b_flush = 1'b1; cyc(); b_flush = 1'b0;
    post_clear_b("flush");
    phase_after_clear_b("flush");

    // async reset mid-stream
    fill_b_for_flush();
    #2 rst = 1'b1;
    #1 post_clear_b("arst");
    #1 rst = 1'b0;
    cyc();
    phase_after_clear_b("arst");

    // randomized traffic on DECIM=4 against a queue model
    flush_b();
    q.delete(); pv = 0; pval = 0; movf = 0; msat = 0; mdrop = 0; nin = 0;
    for (int c = 0; c < 400; c++) begin
      iv = ($urandom_range(0, 3) != 0);
      y = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 65535)) - 32768
                                      : int'($urandom_range(0, 4095)) - 2048;
      mr = (c < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      b_in_valid = iv; b_y = 16'(y); b_m_ready = mr;
      pop = (q.size() > 0) && mr;
      if (pop) void'(q.pop_front());
      if (pv) begin
        if (q.size() < 8) q.push_back(pval);
        else begin
          movf = 1'b1;
          if (mdrop < 255) mdrop++;
        end
      end
      pv = 1'b0;
      if (iv) begin
        if (nin % 4 == 0) begin
          ref_val(y, pval, psat);
          pv = 1'b1;
          if (psat) msat = 1'b1;
        end
        nin++;
      end
      cyc();
      chk($sformatf("rnd%0d_count", c), b_count, q.size());
      chk($sformatf("rnd%0d_mvalid", c), b_m_valid, q.size() > 0);
      if (q.size() > 0) chk($sformatf("rnd%0d_mdata", c), b_m_data, q[0]);
      chk($sformatf("rnd%0d_ovf", c), b_ovf, movf);
      chk($sformatf("rnd%0d_sat", c), b_sat, msat);
      chk($sformatf("rnd%0d_drop", c), b_drop, mdrop);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
